// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
// Address/control stage in front of the left/right LED pattern ROMs.
// It divides clk down to a visible step rate and walks rom_addr. It handles
// run/pause/stop/single-step control and direction selection. led_valid
// is aligned with the ROM's synchronous read latency.
//
// Control inputs are single-cycle pulses, sampled on every rising edge; there
// is no handshake. Among the state controls, stop beats start and start beats
// pause. A step coincident with start or stop is dropped. A dir_toggle
// coincident with stop is dropped.
// The FSM state is held in the enum register "state" for checker binding.
module led_pattern_sequencer #(
   parameter int PRESCALE = 50000000,
   parameter int ADDR_W   = 12,
   parameter int ADDR_MAX = 4095,
   parameter int ROM_LAT  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              pause,
   input  logic              stop,
   input  logic              step,
   input  logic              dir_toggle,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              dir_sel,
   output logic              step_tick,
   output logic              led_valid,
   output logic              busy
);

   localparam int CNT_W = $clog2(PRESCALE);
   localparam int VAL_W = $clog2(ROM_LAT + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PRESCALE - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_MAX);
   localparam logic [VAL_W-1:0]  VAL_FULL  = VAL_W'(ROM_LAT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic                dir_nxt;
   logic                pend;
   logic                pend_nxt;
   logic                pend_eff;
   logic                adv;
   logic                active;
   logic                qual;
   logic [VAL_W-1:0]    val_cnt;

   assign active = (state != S_IDLE);
   assign rom_en = active;
   assign busy   = active;

   // Next-state selection: stop > start > pause.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start && !stop) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (stop)                 state_nxt = S_IDLE;
            else if (pause && !start) state_nxt = S_PAUSE;
         end
         S_PAUSE: begin
            if (stop)       state_nxt = S_IDLE;
            else if (start) state_nxt = S_RUN;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Prescaler, address advance and direction/pending-flip handling.
   always_comb begin
      cnt_nxt  = cnt;
      addr_nxt = rom_addr;
      dir_nxt  = dir_sel;
      pend_nxt = pend;
      pend_eff = pend ^ dir_toggle;
      adv      = 1'b0;
      if (state == S_IDLE) begin
         // ROM is disabled, so the direction may change at once.
         if (dir_toggle) dir_nxt = ~dir_sel;
      end else if (state_nxt == S_IDLE) begin
         addr_nxt = '0;
         cnt_nxt  = '0;
         pend_nxt = 1'b0;
      end else begin
         pend_nxt = pend_eff;
         // Count only while staying in RUN so a pause freezes the phase.
         if (state == S_RUN && state_nxt == S_RUN) begin
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
               adv     = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         if (state == S_PAUSE && state_nxt == S_PAUSE && step) adv = 1'b1;
         if (adv) begin
            if (pend_eff) begin
               // Direction and address change together on one edge.
               dir_nxt  = ~dir_sel;
               addr_nxt = '0;
               pend_nxt = 1'b0;
            end else begin
               addr_nxt = (rom_addr == ADDR_LAST) ? '0 : rom_addr + 1'b1;
            end
         end
      end
   end

   // The ROM captures a stable address on this edge only if it was enabled
   // before the edge, stays enabled, and nothing moves on this edge.
   assign qual = active && (state_nxt != S_IDLE) && !adv;

   // State, datapath and tick registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         rom_addr  <= '0;
         dir_sel   <= 1'b0;
         pend      <= 1'b0;
         step_tick <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rom_addr  <= addr_nxt;
         dir_sel   <= dir_nxt;
         pend      <= pend_nxt;
         step_tick <= adv;
      end
   end

   // Saturating count of consecutive stable ROM captures; full depth means
   // the ROM output reflects the current rom_addr/dir_sel.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         val_cnt <= '0;
      end else if (!qual) begin
         val_cnt <= '0;
      end else if (val_cnt != VAL_FULL) begin
         val_cnt <= val_cnt + 1'b1;
      end
   end

   assign led_valid = (val_cnt == VAL_FULL);

endmodule
